alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port op  input  3  opcode.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port flags  output  4  {Z, N, C, V}, bit 3 = Z.
REQ-013 SHALL have port ops_done  output  8  count of results delivered.

Function
REQ-014 SHALL implement two registered stages: S1 (operand capture: op, a, b, valid) and S2 (result capture: result, flags, valid).
REQ-015 SHALL accept a request when in_valid && in_ready; accepted operands load S1 on that edge.
REQ-016 SHALL drive in_ready = !S1.valid || (S1 advances this cycle); S1 advances when !S2.valid || out_ready.
REQ-017 SHALL compute result/flags combinationally from S1 and load S2 when S1.valid and S1 advances; S2.valid clears when out_ready && !S1 advancing-with-valid.
REQ-018 SHALL give latency of exactly 2 cycles from accept edge to out_valid high when no stall.
REQ-019 SHALL sustain one result per cycle when in_valid and out_ready stay high.
REQ-020 SHALL hold result, flags, out_valid stable while out_valid && !out_ready; S1 holds likewise when blocked.
REQ-021 SHALL preserve issue order; no request dropped or duplicated under any valid/ready pattern.
REQ-022 SHALL decode op: 000 AND, 001 OR, 010 XOR, 011 ADD a+b, 100 SUB a-b, 101 NOT a, 110 SHL a by 1, 111 SHR a by 1 (logical).
REQ-023 SHALL truncate results to WIDTH bits (wrap-around modulo 2^WIDTH).
REQ-024 SHALL set Z = (result == 0), N = result[WIDTH-1] for all opcodes.
REQ-025 SHALL set C: ADD carry-out; SUB 1 when a >= b unsigned (no borrow); SHL bit shifted out a[WIDTH-1]; SHR bit shifted out a[0]; 0 otherwise.
REQ-026 SHALL set V: ADD/SUB two's-complement signed overflow; 0 for all other opcodes.
REQ-027 SHALL increment ops_done on each out_valid && out_ready edge, wrapping 255 -> 0.
REQ-028 SHALL, with simultaneous accept into S1 and S1->S2 transfer and S2 handoff in one cycle, perform all three without loss.

Reset
REQ-029 SHALL on rst high, immediately and independent of clk, clear S1.valid, S2.valid, result, flags, ops_done to 0; in-flight operations are discarded.
REQ-030 SHALL drive in_ready high, out_valid low while rst is high and on the first edge after release.
REQ-031 SHALL accept no request on any edge where rst is high.

Verification
REQ-032 SHALL cover: WIDTH=4, XOR a=1010 b=1100, out_ready=1 -> 2 cycles later out_valid=1, result=0110, flags=0000.
REQ-033 SHALL cover: ADD a=0111 b=0001 -> result=1000, Z0 N1 C0 V1; ADD 1111+0001 -> result=0000, Z1 N0 C1 V0.
REQ-034 SHALL cover: SUB a=0011 b=0011 -> result=0000, Z1 N0 C1 V0; SUB 0000-0001 -> result=1111, Z0 N1 C0 V0.
REQ-035 SHALL cover: out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on third, outputs held; out_ready=1 -> three results in issue order, ops_done=3.
REQ-036 SHALL cover: rst asserted mid-cycle with both stages valid -> out_valid=0, ops_done=0 before next clk edge; after release first new request yields correct result 2 cycles after accept.
REQ-037 SHALL cover: 256 back-to-back results with out_ready=1 -> one result per cycle, ops_done wraps to 0.

Source files
------------

// File: rtl/alu_pipe.sv
//==============================================================================
// Module  : alu_pipe
// Brief   : Two-stage valid/ready ALU pipeline (operand stage, result stage).
// Revision: 1.0
//==============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [7:0]       ops_done
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_XOR = 3'b010;
    localparam logic [2:0] c_OP_ADD = 3'b011;
    localparam logic [2:0] c_OP_SUB = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_SHR = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic [3:0]       flags_q,    flags_d;
    logic [7:0]       ops_done_q, ops_done_d;

    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    // S1 may move on whenever the result stage is empty or being drained.
    assign w_s1_adv  = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign ops_done  = ops_done_q;

    assign w_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign w_diff = {1'b0, s1_a_q} - {1'b0, s1_b_q};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (s1_op_q)
            c_OP_AND: w_res = s1_a_q & s1_b_q;
            c_OP_OR:  w_res = s1_a_q | s1_b_q;
            c_OP_XOR: w_res = s1_a_q ^ s1_b_q;
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            c_OP_SUB: begin
                // Carry means "no borrow", i.e. a >= b unsigned.
                w_res = w_diff[WIDTH-1:0];
                w_c   = !w_diff[WIDTH];
                w_v   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            c_OP_NOT: w_res = ~s1_a_q;
            c_OP_SHL: begin
                w_res = {s1_a_q[WIDTH-2:0], 1'b0};
                w_c   = s1_a_q[WIDTH-1];
            end
            c_OP_SHR: begin
                w_res = {1'b0, s1_a_q[WIDTH-1:1]};
                w_c   = s1_a_q[0];
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        ops_done_d = ops_done_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_valid_q && w_s1_adv) begin
            s2_valid_d = 1'b1;
            result_d   = w_res;
            flags_d    = {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (s2_valid_q && out_ready) begin
            ops_done_d = ops_done_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'b000;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= 4'b0000;
            ops_done_q <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            ops_done_q <= ops_done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//==============================================================================
// Module  : tb_alu_pipe
// Brief   : Directed self-checking bench for alu_pipe with a reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_alu_pipe;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [7:0]   ops_done;

    int           n_vec = 0;
    int           n_err = 0;
    int           exp_q[$];
    int           exp_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_r = '0;
    logic [3:0]   prev_f = '0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: returns result*16 + {Z,N,C,V}.
    function automatic int model(input int fop, input int fa, input int fb);
        int r, c, v, s, sa, sb;
        c  = 0;
        v  = 0;
        sa = (fa >= M / 2) ? fa - M : fa;
        sb = (fb >= M / 2) ? fb - M : fb;
        case (fop)
            0: r = fa & fb;
            1: r = fa | fb;
            2: r = fa ^ fb;
            3: begin
                r = (fa + fb) % M;
                c = (fa + fb >= M) ? 1 : 0;
                s = sa + sb;
                v = (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
            end
            4: begin
                r = (fa - fb + M) % M;
                c = (fa >= fb) ? 1 : 0;
                s = sa - sb;
                v = (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
            end
            5: r = M - 1 - fa;
            6: begin
                r = (fa * 2) % M;
                c = (fa >= M / 2) ? 1 : 0;
            end
            default: begin
                r = fa / 2;
                c = fa % 2;
            end
        endcase
        return r * 16 + ((r == 0) ? 8 : 0) + ((r >= M / 2) ? 4 : 0) + c * 2 + v;
    endfunction

    // Scoreboard / compare process, sampling midway between rising edges.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_ops_done", {24'd0, ops_done}, 32'd0);
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, result, flags}, {24'd0, prev_r, prev_f});
            end
            chk("mon_ops_done", {24'd0, ops_done}, exp_cnt % 256);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got result %0h with no request outstanding", result);
                end else begin
                    chk("mon_data", {24'd0, result, flags}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
            prev_stall = out_valid && !out_ready;
            prev_r     = result;
            prev_f     = flags;
        end
    end

    // Presents a request from posedge+1 and returns at posedge+1 after it is taken.
    task automatic push(input int pop, input int pa, input int pb);
        int k;
        in_valid = 1'b1;
        op = pop[2:0];
        a  = pa[W-1:0];
        b  = pb[W-1:0];
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("push_timeout", {31'd0, (k < 50)}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) break;
        end
        chk("drain_timeout", {31'd0, (k < 50)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input int pop, input int pa, input int pb,
                                  input int er, input int ef);
        out_ready = 1'b1;
        push(pop, pa, pb);
        chk("lat_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_result", {28'd0, result}, er);
        chk("lat_flags", {28'd0, flags}, ef);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {28'd0, result}, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        chk("model_xor", model(2, 10, 12), 32'h60);
        chk("model_add_v", model(3, 7, 1), 32'h85);
        chk("model_add_c", model(3, 15, 1), 32'h0A);
        chk("model_sub_eq", model(4, 3, 3), 32'h0A);
        chk("model_sub_bw", model(4, 0, 1), 32'hF4);

        // Backpressure: two accepted, third refused, outputs frozen.
        out_ready = 1'b0;
        push(0, 12, 10);
        push(1, 3, 4);
        in_valid = 1'b1;
        op = 3'd5;
        a  = 4'd5;
        b  = 4'd0;
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", {28'd0, result}, 32'h8);
            chk("stall_flags", {28'd0, flags}, 32'h4);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(5, 5, 0);
        wait_idle();
        chk("stall_ops_done", {24'd0, ops_done}, 32'd3);

        send_and_check(2, 4'b1010, 4'b1100, 4'b0110, 4'b0000);
        send_and_check(3, 4'b0111, 4'b0001, 4'b1000, 4'b0101);
        send_and_check(3, 4'b1111, 4'b0001, 4'b0000, 4'b1010);
        send_and_check(4, 4'b0011, 4'b0011, 4'b0000, 4'b1010);
        send_and_check(4, 4'b0000, 4'b0001, 4'b1111, 4'b0100);
        send_and_check(6, 4'b1001, 4'b0000, 4'b0010, 4'b0010);
        send_and_check(7, 4'b0011, 4'b0000, 4'b0001, 4'b0010);
        send_and_check(5, 4'b0000, 4'b0000, 4'b1111, 4'b0100);
        send_and_check(4, 4'b1000, 4'b0001, 4'b0111, 4'b0011);

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        push(0, 15, 15);
        push(1, 1, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_ops_done", {24'd0, ops_done}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("async_hold_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        send_and_check(3, 4'b0010, 4'b0011, 4'b0101, 4'b0000);

        // 256 back-to-back operations from a clean counter.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            op = 3'(i % 8);
            a  = 4'(i % 16);
            b  = 4'((i * 7 + 3) % 16);
            @(negedge clk);
            chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
            if (i >= 2) chk("burst_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        chk("burst_wrap", {24'd0, ops_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
